// File: rtl/risc16b_mmio_if.sv
// risc16b_mmio_if: data-bus view of the risc16b MMIO window.
// master drives d_addr/d_oe/d_we/d_dout; slave returns io_sel/io_rdata.
interface risc16b_mmio_if;
    logic [15:0] d_addr;
    logic        d_oe;
    logic [1:0]  d_we;
    logic [15:0] d_dout;
    logic        io_sel;
    logic [15:0] io_rdata;

    modport master (
        output d_addr, d_oe, d_we, d_dout,
        input  io_sel, io_rdata
    );

    modport slave (
        input  d_addr, d_oe, d_we, d_dout,
        output io_sel, io_rdata
    );
endinterface

// File: rtl/risc16b_mmio.sv
// risc16b_mmio: 0x7fxx I/O slave with LED reg, FIFO-fed UART TX, STATUS, CYCLES.
// Ports: clk, rst (sync, high), bus (slave), led, uart_txd; CYCLES needs RISC16B_MMIO_CYCLES_EN.
module risc16b_mmio #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    risc16b_mmio_if.slave  bus,
    output logic [15:0]    led,
    output logic           uart_txd
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned BAUD_LAST_I = CLK_DIV - 1;
    localparam logic [15:0] BAUD_LAST = BAUD_LAST_I[15:0];
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    // ---------------- address decode ----------------
    logic [6:0]  idx;
    logic        wr;
    logic        wr_led;
    logic        wr_stat;
    logic        push_req;
    logic        unused_addr0;

    assign idx          = bus.d_addr[7:1];
    assign bus.io_sel   = (bus.d_addr[15:8] == 8'h7f);
    assign wr           = bus.io_sel && (bus.d_we != 2'b00);
    assign wr_led       = wr && (idx == 7'h00);
    assign push_req     = wr && (idx == 7'h01) && bus.d_we[1];
    assign wr_stat      = wr && (idx == 7'h02);
    assign unused_addr0 = bus.d_addr[0];

    // ---------------- LED register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 16'h0000;
        end else if (wr_led) begin
            if (bus.d_we[0]) led[15:8] <= bus.d_dout[15:8];
            if (bus.d_we[1]) led[7:0]  <= bus.d_dout[7:0];
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_ok;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.d_dout[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a rejected push beats a clearing STATUS write.
    logic ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (push_req && !push_ok) begin
            ovf <= 1'b1;
        end else if (wr_stat) begin
            ovf <= 1'b0;
        end
    end

    // ---------------- UART transmitter ----------------
    tx_state_t   state;
    tx_state_t   state_n;
    logic [15:0] baud;
    logic [15:0] baud_n;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_n;
    logic [7:0]  shreg;
    logic [7:0]  shreg_n;
    logic        baud_end;
    logic        busy;

    assign baud_end = (baud == BAUD_LAST);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= 16'h0000;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud + 16'd1;
        bit_n   = bit_idx;
        shreg_n = shreg;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                baud_n = 16'h0000;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = mem[rd_ptr];
                    state_n = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_n  = 16'h0000;
                    bit_n   = 3'd0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_n  = 16'h0000;
                    shreg_n = shreg >> 1;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_n = 16'h0000;
                    // Chain straight into the next frame when data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_n = mem[rd_ptr];
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        uart_txd = 1'b1;
        unique case (state)
            S_START: uart_txd = 1'b0;
            S_DATA:  uart_txd = shreg[0];
            default: uart_txd = 1'b1;
        endcase
    end

    // ---------------- cycle counter ----------------
    logic [15:0] cyc_rd;

`ifdef RISC16B_MMIO_CYCLES_EN
    logic [15:0] cycles;
    logic        wr_cyc;

    assign wr_cyc = wr && (idx == 7'h03);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycles <= 16'h0000;
        end else if (wr_cyc) begin
            cycles <= 16'h0000;
        end else begin
            cycles <= cycles + 16'd1;
        end
    end

    assign cyc_rd = cycles;
`else
    assign cyc_rd = 16'h0000;
`endif

    // ---------------- read mux ----------------
    logic [15:0] status;
    logic [15:0] rdata;

    assign status = {12'h000, ovf, empty, busy, full};

    always_comb begin
        rdata = 16'h0000;
        if (bus.d_oe && bus.io_sel) begin
            case (idx)
                7'h00:   rdata = led;
                7'h02:   rdata = status;
                7'h03:   rdata = cyc_rd;
                default: rdata = 16'h0000;
            endcase
        end
    end

    assign bus.io_rdata = rdata;

endmodule
